// File: rtl/stream_upsizer_arbiter.sv
// Round-robin arbiter that funnels N narrow streams into one stream_upsizer input.
// Grants end only on upsizer word boundaries; a short packet tail is completed with zero pad beats.
module stream_upsizer_arbiter #(
  parameter int N         = 4,
  parameter int DW_IN     = 8,
  parameter int SCALE     = 4,
  parameter int MAX_BEATS = 16,
  parameter int IDW       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*DW_IN-1:0]   s_data_i,
  input  logic [N-1:0]         s_valid_i,
  input  logic [N-1:0]         s_last_i,
  output logic [N-1:0]         s_ready_o,
  output logic [DW_IN-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [IDW-1:0]       m_id_o,
  output logic                 m_pad_o,
  output logic                 busy_o,
  output logic [1:0]           dbg_state_o
);

  localparam int LW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  // Handshake: a beat moves when valid and ready are both high at the rising edge;
  // valid never depends on ready, and once raised in PAD it holds until accepted.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_PAD   = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, rr_n;
  logic [LW-1:0]  lane, lane_n;
  logic [BW-1:0]  beats, beats_n;
  logic [IDW-1:0] id_n;
  logic [IDW-1:0] id_inc;
  logic           lane_last;
  logic           xfer;
  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  int             pick_idx;

  assign lane_last   = (lane == LW'(SCALE - 1));
  assign id_inc      = (m_id_o == IDW'(N - 1)) ? '0 : m_id_o + IDW'(1);
  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

  // Walk downward so the channel closest above rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      pick_idx = int'(rr_ptr) + i;
      if (pick_idx >= N) pick_idx = pick_idx - N;
      if (s_valid_i[pick_idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(pick_idx);
      end
    end
  end

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    lane_n    = lane;
    beats_n   = beats;
    id_n      = m_id_o;
    s_ready_o = '0;
    m_data_o  = '0;
    m_valid_o = 1'b0;
    m_pad_o   = 1'b0;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        beats_n = '0;
        lane_n  = '0;
        if (pick_valid) begin
          id_n    = pick_id;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        m_data_o          = s_data_i[m_id_o*DW_IN +: DW_IN];
        m_valid_o         = s_valid_i[m_id_o];
        s_ready_o[m_id_o] = m_ready_i;
        xfer              = m_valid_o & m_ready_i;
        if (xfer) begin
          if (s_last_i[m_id_o]) begin
            if (lane_last) begin
              state_n = ST_IDLE;
              rr_n    = id_inc;
            end else begin
              state_n = ST_PAD;
            end
          end else if (beats == BW'(MAX_BEATS - 1)) begin
            // MAX_BEATS is a multiple of SCALE, so lane is also at the word end here.
            state_n = ST_IDLE;
            rr_n    = id_inc;
          end
        end
      end
      ST_PAD: begin
        m_valid_o = 1'b1;
        m_pad_o   = 1'b1;
        xfer      = m_ready_i;
        if (xfer && lane_last) begin
          state_n = ST_IDLE;
          rr_n    = id_inc;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (xfer) begin
      lane_n  = lane_last ? '0 : lane + LW'(1);
      beats_n = beats + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      lane   <= '0;
      beats  <= '0;
      m_id_o <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_n;
      lane   <= lane_n;
      beats  <= beats_n;
      m_id_o <= id_n;
    end
  end

endmodule

// File: tb/tb_stream_upsizer_arbiter.sv
// Bench for stream_upsizer_arbiter: queue-fed requesters, expected-beat scoreboard,
// a table of single-packet vectors and hand-written multi-cycle sequences.
module tb_stream_upsizer_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;
  localparam int W   = IDW + 1 + DW;

  typedef struct {
    int         ch;
    int         len;
    logic [7:0] base;
    int         exp_pads;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [N*DW-1:0]   s_data_i;
  logic [N-1:0]      s_valid_i;
  logic [N-1:0]      s_last_i;
  logic [N-1:0]      s_ready_o;
  logic [DW-1:0]     m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [IDW-1:0]    m_id_o;
  logic              m_pad_o;
  logic              busy_o;
  logic [1:0]        dbg_state_o;

  stream_upsizer_arbiter #(
    .N(N), .DW_IN(DW), .SCALE(4), .MAX_BEATS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_id_o(m_id_o), .m_pad_o(m_pad_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]    src_q [N][$];
  logic [W-1:0]  exp_q[$];
  logic [31:0]   exp_word_q[$];
  vec_t          vecs[7];

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            bp_mode = 0;
  int            pad_cnt, xfer_cnt, first_xfer_cyc, last_xfer_cyc, wl;
  bit            first_seen, chk_gap, have_prev, prev_pad_stall;
  logic [IDW-1:0] prev_id;
  logic [31:0]   word_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit srcs_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // driver
  task automatic drive();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        s_valid_i[k]          = 1'b1;
        s_data_i[k*DW +: DW]  = src_q[k][0][7:0];
        s_last_i[k]           = src_q[k][0][8];
      end else begin
        s_valid_i[k]          = 1'b0;
        s_data_i[k*DW +: DW]  = '0;
        s_last_i[k]           = 1'b0;
      end
    end
    case (bp_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = pat[cyc % 4];
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  // scoreboard / monitor, sampled on the falling edge
  task automatic monitor();
    bit           xfer;
    logic [W-1:0] e;
    xfer = m_valid_o && m_ready_i;
    if (prev_pad_stall) begin
      chk("pad_hold_valid", 32'(m_valid_o), 32'd1);
      chk("pad_hold_pad", 32'(m_pad_o), 32'd1);
    end
    prev_pad_stall = m_valid_o && m_pad_o && !m_ready_i;
    if (xfer) begin
      if (!first_seen) begin
        first_seen     = 1'b1;
        first_xfer_cyc = cyc;
      end
      xfer_cnt++;
      if (m_pad_o) pad_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got id=%0d pad=%0d data=%0h, want no beat", m_id_o, m_pad_o, m_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat{id,pad,data}", 32'({m_id_o, m_pad_o, m_data_o}), 32'(e));
      end
      if (chk_gap && have_prev && m_id_o != prev_id)
        chk("rr_gap_cycles", 32'(cyc - last_xfer_cyc), 32'd2);
      have_prev     = 1'b1;
      prev_id       = m_id_o;
      last_xfer_cyc = cyc;
      word_acc[wl*8 +: 8] = m_data_o;
      wl++;
      if (wl == 4) begin
        wl = 0;
        if (exp_word_q.size() > 0) chk("word", word_acc, exp_word_q.pop_front());
      end
    end
    for (int k = 0; k < N; k++)
      if (s_valid_i[k] && s_ready_o[k]) void'(src_q[k].pop_front());
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(srcs_empty() && exp_q.size() == 0 && !busy_o) && n < 400) begin
      cycle();
      n++;
    end
    chk({name, "_completed_in_budget"}, 32'(n < 400), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_m_pad"}, 32'(m_pad_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_m_id"}, 32'(m_id_o), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state_o), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_reset_outs(tag);
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    exp_word_q.delete();
    s_valid_i      = '0;
    s_last_i       = '0;
    s_data_i       = '0;
    m_ready_i      = 1'b0;
    wl             = 0;
    have_prev      = 1'b0;
    prev_pad_stall = 1'b0;
    chk_gap        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [7:0] base, input bit with_last);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = base + 8'(i);
      src_q[ch].push_back({with_last && (i == len - 1), d});
    end
  endtask

  task automatic push_exp(input int ch, input int len, input logic [7:0] base, input int pads);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = base + 8'(i);
      exp_q.push_back({IDW'(ch), 1'b0, d});
    end
    for (int i = 0; i < pads; i++) exp_q.push_back({IDW'(ch), 1'b1, 8'h00});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ch, len, pads, start;
    rst_n     = 1'b1;
    s_valid_i = '0;
    s_last_i  = '0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    vecs[0] = '{1, 8, 8'h10, 0};
    vecs[1] = '{0, 5, 8'hA0, 3};
    vecs[2] = '{3, 1, 8'h30, 3};
    vecs[3] = '{2, 4, 8'h40, 0};
    vecs[4] = '{1, 7, 8'h50, 1};
    vecs[5] = '{3, 16, 8'h60, 0};
    vecs[6] = '{0, 14, 8'h80, 2};
    #2;
    do_reset("reset");

    // table of single packets
    foreach (vecs[v]) begin
      pad_cnt    = 0;
      xfer_cnt   = 0;
      first_seen = 1'b0;
      send_pkt(vecs[v].ch, vecs[v].len, vecs[v].base, 1'b1);
      push_exp(vecs[v].ch, vecs[v].len, vecs[v].base, vecs[v].exp_pads);
      start = cyc;
      wait_idle("vec");
      chk("vec_pad_count", 32'(pad_cnt), 32'(vecs[v].exp_pads));
      chk("vec_xfer_count", 32'(xfer_cnt), 32'(vecs[v].len + vecs[v].exp_pads));
      chk("vec_first_latency", 32'(first_xfer_cyc - start), 32'd1);
      chk("vec_busy_end", 32'(busy_o), 32'd0);
    end

    // after ch1 finishes, rr_ptr=2: ch2 beats ch0
    do_reset("rst_rr");
    send_pkt(1, 8, 8'h10, 1'b1);
    push_exp(1, 8, 8'h10, 0);
    wait_idle("single_ch1");
    send_pkt(0, 4, 8'h01, 1'b1);
    send_pkt(2, 4, 8'h21, 1'b1);
    push_exp(2, 4, 8'h21, 0);
    push_exp(0, 4, 8'h01, 0);
    wait_idle("rr_after_single");

    // mid-word last: words must never mix channels
    do_reset("rst_midword");
    exp_word_q.push_back(32'hA3A2A1A0);
    exp_word_q.push_back(32'h000000A4);
    send_pkt(0, 5, 8'hA0, 1'b1);
    push_exp(0, 5, 8'hA0, 3);
    wait_idle("midword");
    chk("midword_words_seen", 32'(exp_word_q.size()), 32'd0);

    // budget exit after 16 beats, ch3 takes a turn, ch2 resumes at beat 17
    do_reset("rst_budget");
    send_pkt(2, 20, 8'hC0, 1'b1);
    send_pkt(3, 4, 8'h70, 1'b1);
    push_exp(2, 16, 8'hC0, 0);
    push_exp(3, 4, 8'h70, 0);
    push_exp(2, 4, 8'hD0, 0);
    wait_idle("budget");

    // round robin with one bubble between grants
    do_reset("rst_rr4");
    chk_gap = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N; c++) begin
        send_pkt(c, 4, 8'(c * 16 + p * 4), 1'b1);
        push_exp(c, 4, 8'(c * 16 + p * 4), 0);
      end
    wait_idle("round_robin");
    chk_gap = 1'b0;

    // back-pressure 1,0,0,1 in GRANT and PAD
    do_reset("rst_bp");
    bp_mode = 1;
    pad_cnt = 0;
    send_pkt(0, 6, 8'hE0, 1'b1);
    push_exp(0, 6, 8'hE0, 2);
    wait_idle("bp_ch0");
    send_pkt(1, 3, 8'hF0, 1'b1);
    push_exp(1, 3, 8'hF0, 1);
    wait_idle("bp_ch1");
    chk("bp_pad_count", 32'(pad_cnt), 32'd3);

    // random lengths under random back-pressure
    bp_mode = 2;
    for (int r = 0; r < 4; r++) begin
      ch      = $urandom_range(0, N - 1);
      len     = $urandom_range(1, 16);
      pads    = (4 - (len % 4)) % 4;
      pad_cnt = 0;
      send_pkt(ch, len, 8'(r * 32), 1'b1);
      push_exp(ch, len, 8'(r * 32), pads);
      wait_idle("rand_pkt");
      chk("rand_pad_count", 32'(pad_cnt), 32'(pads));
    end
    bp_mode = 0;

    // reset while padding: rr_ptr must return to 0
    do_reset("rst_midpad_pre");
    send_pkt(2, 4, 8'h90, 1'b1);
    push_exp(2, 4, 8'h90, 0);
    wait_idle("pre_pad_ch2");
    send_pkt(1, 5, 8'hB0, 1'b1);
    push_exp(1, 5, 8'hB0, 0);
    n = 0;
    while (!m_pad_o && n < 50) begin
      cycle();
      n++;
    end
    chk("reached_pad", 32'(m_pad_o), 32'd1);
    chk("pad_valid_high", 32'(m_valid_o), 32'd1);
    do_reset("midpad_reset");
    send_pkt(3, 4, 8'h33, 1'b1);
    send_pkt(2, 4, 8'h22, 1'b1);
    push_exp(2, 4, 8'h22, 0);
    push_exp(3, 4, 8'h33, 0);
    wait_idle("after_midpad");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
